// File: rtl/turn_sequencer.sv
// ---------------------------------------------------------------------------
// turn_sequencer
//
// Purpose:
//   Turn controller for a 4x4 2048 board. Owns the 64-bit board register and
//   runs one move at a time: hand the board to the external shift/merge
//   engine, commit its result, spawn a single new tile, then evaluate
//   game-over. A tile is spawned only when the engine reports that the move
//   changed the board. The first tile of a game is spawned on the cycle
//   after reset.
//
// Cell layout:
//   Cell i (0..15) is at row i/4, column i%4, stored in board[63-4i -: 4].
//   Cell code 0 means the cell is empty. Other codes are only compared for
//   equality.
//
// Parameters:
//   SPAWN_CODE     tile code written into the spawned cell
//   SHIFT_TIMEOUT  cycles spent waiting for shift_done before the turn is
//                  abandoned (1..255)
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high
//   move_valid   in   move request
//   move_dir     in   0=up 1=down 2=left 3=right, taken with the handshake
//   move_ready   out  high in IDLE while the game is not over
//   shift_start  out  one-cycle start pulse to the shift/merge engine
//   shift_dir    out  accepted direction, held for the engine
//   shift_done   in   engine result strobe
//   shift_board  in   engine result board
//   shift_moved  in   engine result differs from the board it was given
//   rand_pos     in   free-running random cell index
//   board        out  committed board
//   spawn_valid  out  one-cycle pulse when a tile was written
//   spawn_pos    out  index of the last written tile
//   game_over    out  sticky until reset
//   timeout_err  out  one-cycle pulse when a turn was abandoned
// ---------------------------------------------------------------------------
module turn_sequencer #(
    parameter logic [3:0] SPAWN_CODE    = 4'b0010,
    parameter int         SHIFT_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    output logic        move_ready,
    output logic        shift_start,
    output logic [1:0]  shift_dir,
    input  logic        shift_done,
    input  logic [63:0] shift_board,
    input  logic        shift_moved,
    input  logic [3:0]  rand_pos,
    output logic [63:0] board,
    output logic        spawn_valid,
    output logic [3:0]  spawn_pos,
    output logic        game_over,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_START = 3'd2,
        S_WAIT  = 3'd3,
        S_SPAWN = 3'd4,
        S_CHECK = 3'd5
    } state_t;

    // The wait timer counts 0,1,..; the turn is abandoned on the cycle the
    // timer holds SHIFT_TIMEOUT-1, so the error pulse appears exactly
    // SHIFT_TIMEOUT cycles after entering WAIT.
    localparam logic [7:0] TIMER_LAST = 8'(SHIFT_TIMEOUT - 1);

    state_t        r_state;
    logic [63:0]   r_board;
    logic          r_shift_start;
    logic [1:0]    r_shift_dir;
    logic          r_spawn_valid;
    logic [3:0]    r_spawn_pos;
    logic          r_game_over;
    logic          r_timeout_err;
    logic [7:0]    r_timer;

    logic [15:0]   w_empty;
    logic          w_any_empty;
    logic [3:0]    w_lowest_empty;
    logic [3:0]    w_target;
    logic [63:0]   w_spawn_board;
    logic          w_equal_pair;
    logic          w_move_ready;

    function automatic logic [3:0] cell_of(input logic [63:0] b, input int idx);
        return b[63 - 4*idx -: 4];
    endfunction

    // -----------------------------------------------------------------------
    // Board analysis, all from the board register
    // -----------------------------------------------------------------------
    always_comb begin
        w_empty = '0;
        for (int i = 0; i < 16; i++) begin
            w_empty[i] = (cell_of(r_board, i) == 4'd0);
        end
    end

    assign w_any_empty = |w_empty;

    // Scan from the top index down so the last hit is the lowest empty cell.
    always_comb begin
        w_lowest_empty = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_empty[i]) begin
                w_lowest_empty = 4'(i);
            end
        end
    end

    // Prefer the random cell; fall back to the lowest empty cell so a spawn
    // always lands in one cycle instead of re-rolling.
    assign w_target = w_empty[rand_pos] ? rand_pos : w_lowest_empty;

    always_comb begin
        w_spawn_board = r_board;
        w_spawn_board[63 - 4*w_target -: 4] = SPAWN_CODE;
    end

    // Any equal horizontal or vertical neighbour means a merge is still
    // possible even on a full board.
    always_comb begin
        w_equal_pair = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (cell_of(r_board, r*4 + c) == cell_of(r_board, r*4 + c + 1)) begin
                    w_equal_pair = 1'b1;
                end
            end
        end
        for (int i = 0; i < 12; i++) begin
            if (cell_of(r_board, i) == cell_of(r_board, i + 4)) begin
                w_equal_pair = 1'b1;
            end
        end
    end

    assign w_move_ready = (r_state == S_IDLE) && !r_game_over;

    // -----------------------------------------------------------------------
    // Turn FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_INIT;
            r_board       <= '0;
            r_shift_start <= 1'b0;
            r_shift_dir   <= 2'd0;
            r_spawn_valid <= 1'b0;
            r_spawn_pos   <= 4'd0;
            r_game_over   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_timer       <= 8'd0;
        end else begin
            r_shift_start <= 1'b0;
            r_spawn_valid <= 1'b0;
            r_timeout_err <= 1'b0;

            case (r_state)
                // INIT spawns the first tile on the cleared board using the
                // same path as a normal spawn.
                S_INIT, S_SPAWN: begin
                    if (w_any_empty) begin
                        r_board       <= w_spawn_board;
                        r_spawn_pos   <= w_target;
                        r_spawn_valid <= 1'b1;
                    end
                    r_state <= (r_state == S_INIT) ? S_IDLE : S_CHECK;
                end

                // shift_start is raised on the accepting edge so that it is
                // high during the START cycle.
                S_IDLE: begin
                    if (move_valid && w_move_ready) begin
                        r_shift_dir   <= move_dir;
                        r_shift_start <= 1'b1;
                        r_state       <= S_START;
                    end
                end

                S_START: begin
                    r_timer <= 8'd0;
                    r_state <= S_WAIT;
                end

                // A completion in the same cycle as the timeout wins.
                S_WAIT: begin
                    if (shift_done) begin
                        if (shift_moved) begin
                            r_board <= shift_board;
                            r_state <= S_SPAWN;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (r_timer >= TIMER_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end

                S_CHECK: begin
                    if (!w_any_empty && !w_equal_pair) begin
                        r_game_over <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    assign move_ready  = w_move_ready;
    assign shift_start = r_shift_start;
    assign shift_dir   = r_shift_dir;
    assign board       = r_board;
    assign spawn_valid = r_spawn_valid;
    assign spawn_pos   = r_spawn_pos;
    assign game_over   = r_game_over;
    assign timeout_err = r_timeout_err;

endmodule
